// File: rtl/spi_tx_sched.sv
// spi_tx_sched: RAM-backed byte queue that stages the next byte for an SPI slave.
// Define SPI_TX_SCHED_ECHO_EN to loop every received byte back into the queue.
module spi_tx_sched #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce0,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       ram_we,
  output logic [7:0] ram_waddr,
  output logic [7:0] ram_wdata,
  output logic       ram_re,
  output logic [7:0] ram_raddr,
  input  logic [7:0] ram_rdata,
  output logic [7:0] spi_tx_data,
  input  logic [7:0] spi_rx_data,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic [8:0] count,
  output logic       empty,
  output logic       full,
  output logic       underrun
`ifdef SPI_TX_SCHED_ECHO_EN
  ,
  output logic       echo_drop
`endif
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, STAGED, BUSY
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic ce_s, ce_d;
  logic frame_start, frame_end;
  logic [7:0] wptr, rptr;
  logic fab_push, push, consume;
  logic set_under, load_ram, capture;

  assign ce_s        = sync[SYNC_STAGES-1];
  assign frame_start = ce_d & ~ce_s;
  assign frame_end   = ~ce_d & ce_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
      ce_d <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ce0};
      ce_d <= ce_s;
    end
  end

  assign empty    = (count == 9'd0);
  assign full     = (count == 9'd256);
  assign wr_ready = ~full;
  assign fab_push = wr_valid & ~full;

`ifdef SPI_TX_SCHED_ECHO_EN
  logic       echo_full;
  logic [7:0] echo_data;
  logic       echo_push;

  // Fabric writes win; the echo byte waits for a free write slot.
  assign echo_push = echo_full & ~wr_valid & ~full;
  assign push      = fab_push | echo_push;
  assign ram_wdata = fab_push ? wr_data : echo_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_full <= 1'b0;
      echo_data <= 8'h00;
      echo_drop <= 1'b0;
    end else if (rx_valid) begin
      echo_full <= 1'b1;
      echo_data <= rx_byte;
      if (echo_full && !echo_push)
        echo_drop <= 1'b1;
    end else if (echo_push) begin
      echo_full <= 1'b0;
    end
  end
`else
  assign push      = fab_push;
  assign ram_wdata = wr_data;
`endif

  assign ram_we    = push & reset_n;
  assign ram_waddr = wptr;
  assign ram_raddr = rptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (frame_start)
          state_nx = BUSY;
        else if (count != 9'd0 || push)
          state_nx = FETCH;
      FETCH:
        state_nx = frame_start ? BUSY : LATCH;
      LATCH:
        state_nx = frame_start ? BUSY : STAGED;
      STAGED:
        if (frame_start)
          state_nx = BUSY;
      BUSY:
        if (frame_end)
          state_nx = (count != 9'd0) ? FETCH : IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    ram_re    = (state == FETCH);
    consume   = (state == STAGED) & frame_start;
    set_under = frame_start &
                ((state == IDLE) | (state == FETCH) | (state == LATCH));
    load_ram  = (state == LATCH) & ~frame_start;
    capture   = (state == BUSY) & frame_end;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr        <= 8'h00;
      rptr        <= 8'h00;
      count       <= 9'd0;
      spi_tx_data <= FILL_BYTE;
      rx_byte     <= 8'h00;
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 8'd1;
      if (consume)
        rptr <= rptr + 8'd1;
      count <= count + {8'd0, push} - {8'd0, consume};
      if (set_under) begin
        underrun    <= 1'b1;
        spi_tx_data <= FILL_BYTE;
      end else if (load_ram) begin
        spi_tx_data <= ram_rdata;
      end
      rx_valid <= capture;
      if (capture)
        rx_byte <= spi_rx_data;
    end
  end

endmodule

// File: tb/tb_spi_tx_sched.sv
// Testbench for spi_tx_sched: vector table, corner sequences and a
// randomized run against a queue model; echo checks when SPI_TX_SCHED_ECHO_EN.
module tb_spi_tx_sched;

  localparam int         SYNC = 2;
  localparam logic [7:0] FILL = 8'h5A;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce0 = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       ram_we;
  logic [7:0] ram_waddr, ram_wdata;
  logic       ram_re;
  logic [7:0] ram_raddr;
  logic [7:0] ram_rdata = 8'h00;
  logic [7:0] spi_tx_data;
  logic [7:0] spi_rx_data = 8'h00;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [8:0] count;
  logic       empty, full, underrun;
`ifdef SPI_TX_SCHED_ECHO_EN
  logic       echo_drop;
`endif

  int checks = 0;
  int errs   = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we)
      mem[ram_waddr] <= ram_wdata;
    if (ram_re)
      ram_rdata <= mem[ram_raddr];
  end

  spi_tx_sched #(
    .SYNC_STAGES(SYNC),
    .FILL_BYTE  (FILL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce0        (ce0),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_re     (ram_re),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .spi_tx_data(spi_tx_data),
    .spi_rx_data(spi_rx_data),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .count      (count),
    .empty      (empty),
    .full       (full),
`ifdef SPI_TX_SCHED_ECHO_EN
    .underrun   (underrun),
    .echo_drop  (echo_drop)
`else
    .underrun   (underrun)
`endif
  );

  typedef struct {
    int         npush;
    logic [7:0] base;
    logic [7:0] rx;
    logic [7:0] exp_tx;
    int         exp_before;
    int         exp_after;
    logic       exp_ur;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    ce0         = 1'b1;
    wr_valid    = 1'b0;
    spi_rx_data = 8'h00;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] rx,
                       output logic [7:0] tx,
                       output logic [7:0] rb);
    bit seen;
    int lat;
    seen = 0;
    lat  = 0;
    rb   = 8'h00;
    ce0  = 1'b0;
    repeat (SYNC + 3) step();
    tx          = spi_tx_data;
    spi_rx_data = rx;
    ce0         = 1'b1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      step();
      if (rx_valid) begin
        seen = 1;
        lat  = i;
        rb   = rx_byte;
      end
    end
    chk("rx_valid_seen", int'(seen), 1);
    chk("rx_latency", lat, SYNC + 1);
    step();
    chk("rx_pulse_width", int'(rx_valid), 0);
    repeat (6) step();
  endtask

  vec_t       tbl [6];
  logic [7:0] q [$];
  logic [7:0] tx, rb, b, exp_tx;
  bit         m_ur;
  int         n;

  initial begin
    tbl[0] = '{1, 8'hA5, 8'h3C, 8'hA5, 1, 0, 1'b0};
    tbl[1] = '{3, 8'h10, 8'h55, 8'h10, 3, 2, 1'b0};
    tbl[2] = '{0, 8'h00, 8'h66, 8'h11, 2, 1, 1'b0};
    tbl[3] = '{0, 8'h00, 8'h77, 8'h12, 1, 0, 1'b0};
    tbl[4] = '{0, 8'h00, 8'h88, FILL,  0, 0, 1'b1};
    tbl[5] = '{2, 8'hF0, 8'h99, 8'hF0, 2, 1, 1'b1};

    // reset state
    reset_n = 1'b0;
    repeat (2) step();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_tx", int'(spi_tx_data), int'(FILL));
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_byte", int'(rx_byte), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_ram_re", int'(ram_re), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    reset_n = 1'b1;
    step();

`ifndef SPI_TX_SCHED_ECHO_EN
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < tbl[v].npush; k++)
        push(tbl[v].base + 8'(k));
      repeat (6) step();
      chk($sformatf("tbl%0d_count_before", v), int'(count), tbl[v].exp_before);
      frame(tbl[v].rx, tx, rb);
      chk($sformatf("tbl%0d_tx", v), int'(tx), int'(tbl[v].exp_tx));
      chk($sformatf("tbl%0d_rx_byte", v), int'(rb), int'(tbl[v].rx));
      chk($sformatf("tbl%0d_count_after", v), int'(count), tbl[v].exp_after);
      chk($sformatf("tbl%0d_underrun", v), int'(underrun), int'(tbl[v].exp_ur));
    end
`endif

    // push coinciding with frame_start at count 5
    do_reset();
    for (int k = 0; k < 5; k++)
      push(8'h40 + 8'(k));
    repeat (6) step();
    chk("same_cycle_before", int'(count), 5);
    ce0 = 1'b0;
    repeat (SYNC) step();
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    step();
    wr_valid = 1'b0;
    chk("same_cycle_after", int'(count), 5);
    chk("same_cycle_tx", int'(spi_tx_data), 8'h40);
    ce0 = 1'b1;
    repeat (8) step();

    // fill to 256
    do_reset();
    for (int k = 0; k < 256; k++)
      push(8'(k));
    repeat (4) step();
    chk("full_flag", int'(full), 1);
    chk("full_wr_ready", int'(wr_ready), 0);
    chk("full_count", int'(count), 256);
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    #1;
    chk("full_no_we", int'(ram_we), 0);
    step();
    wr_valid = 1'b0;
    chk("full_257_ignored", int'(count), 256);
`ifndef SPI_TX_SCHED_ECHO_EN
    frame(8'h01, tx, rb);
    chk("full_frame_tx", int'(tx), 8'h00);
    chk("full_frame_count", int'(count), 255);
    chk("full_frame_ready", int'(wr_ready), 1);
    wr_valid = 1'b1;
    wr_data  = 8'hEF;
    #1;
    chk("wrap_we", int'(ram_we), 1);
    chk("wrap_waddr", int'(ram_waddr), 0);
    step();
    wr_valid = 1'b0;
    chk("wrap_count", int'(count), 256);
`endif

    // randomized run against the queue model
    do_reset();
    q.delete();
    m_ur = 0;
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        push(b);
        q.push_back(b);
      end
      repeat (6) step();
      chk("rnd_count", int'(count), q.size());
      chk("rnd_empty", int'(empty), int'(q.size() == 0));
      if (q.size() > 0) begin
        exp_tx = q.pop_front();
      end else begin
        exp_tx = FILL;
        m_ur   = 1;
      end
      b = 8'($urandom);
      frame(b, tx, rb);
      chk("rnd_tx", int'(tx), int'(exp_tx));
      chk("rnd_rx_byte", int'(rb), int'(b));
      chk("rnd_underrun", int'(underrun), int'(m_ur));
`ifdef SPI_TX_SCHED_ECHO_EN
      q.push_back(b);
`endif
    end
    chk("rnd_final_count", int'(count), q.size());

`ifdef SPI_TX_SCHED_ECHO_EN
    // echo waits behind three fabric pushes
    begin
      bit seen;
      do_reset();
      seen = 0;
      ce0  = 1'b0;
      repeat (SYNC + 3) step();
      spi_rx_data = 8'h11;
      ce0         = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
        step();
        if (rx_valid)
          seen = 1;
      end
      chk("echo_rx_seen", int'(seen), 1);
      for (int k = 0; k < 3; k++) begin
        wr_valid = 1'b1;
        wr_data  = 8'h20 + 8'(k);
        #1;
        chk("echo_fabric_first", int'(ram_wdata), 8'h20 + k);
        step();
      end
      wr_valid = 1'b0;
      #1;
      chk("echo_we", int'(ram_we), 1);
      chk("echo_wdata", int'(ram_wdata), 8'h11);
      repeat (6) step();
      chk("echo_count", int'(count), 4);
      chk("echo_drop", int'(echo_drop), 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/spi_tx_sched.md
SPI_TX_SCHED -- requirements
Module: spi_tx_sched

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the ce0 synchronizer depth (legal 2..3).
REQ-002 The block SHALL have parameter FILL_BYTE, default 8'h00, giving the byte presented on underrun.
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ce0  in  1  SPI chip enable from the pin, asynchronous; low marks an active frame.
REQ-006 wr_valid / wr_data  in  1 / 8  fabric push request and byte.
REQ-007 wr_ready  out  1  push accepted this cycle when high with wr_valid.
REQ-008 ram_we / ram_waddr / ram_wdata  out  1 / 8 / 8  write port to the 256x8 RAM.
REQ-009 ram_re / ram_raddr  out  1 / 8  read port; ram_rdata  in  8, valid one clk after ram_re.
REQ-010 spi_tx_data  out  8  byte presented to the SPI slave's outgoing-data input.
REQ-011 spi_rx_data  in  8  SPI slave's incoming-data output, stable after ce0 rises.
REQ-012 rx_valid / rx_byte  out  1 / 8  one-cycle pulse and captured received byte.
REQ-013 count  out  9  queued bytes, 0..256; empty, full  out  1 each; underrun  out  1  sticky.

Function
REQ-014 ce0 SHALL pass through SYNC_STAGES flops; a falling edge of the synchronized value is frame_start, a rising edge is frame_end, each a one-clk event.
REQ-015 Push: wr_ready = !full; on wr_valid&&wr_ready, ram_we=1, ram_waddr=wptr, ram_wdata=wr_data in the same cycle, wptr+1 mod 256 next edge.
REQ-016 States: IDLE, FETCH, LATCH, STAGED, BUSY.
REQ-017 IDLE: when count!=0 go FETCH; on frame_start set underrun, drive FILL_BYTE, go BUSY.
REQ-018 FETCH: ram_re=1, ram_raddr=rptr, go LATCH; LATCH: spi_tx_data<=ram_rdata, go STAGED.
REQ-019 STAGED: on frame_start, consume (rptr+1 mod 256, count-1), go BUSY; spi_tx_data SHALL not change in STAGED or BUSY.
REQ-020 frame_start in FETCH or LATCH: no consume, underrun set, go BUSY; the pending byte is re-fetched later.
REQ-021 BUSY: on frame_end, rx_byte<=spi_rx_data, rx_valid=1 for one clk, go FETCH if count!=0 else IDLE.
REQ-022 frame_end outside BUSY SHALL be ignored (no rx_valid).
REQ-023 count SHALL include the staged byte; push and consume in the same cycle leave count unchanged.
REQ-024 empty = (count==0), full = (count==256), combinational from count.
REQ-025 A byte pushed in cycle N SHALL be in STAGED by N+3 when the FSM was IDLE.
REQ-026 underrun SHALL clear only on reset.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, wptr=rptr=0, count=0, spi_tx_data=FILL_BYTE, rx_byte=0, rx_valid=0, underrun=0, synchronizer flops=1, ram_we=ram_re=0.
REQ-028 Reset mid-frame SHALL discard staged and queued bytes; the first frame_end after reset with no prior frame_start SHALL be ignored.

Configuration
REQ-029 With SPI_TX_SCHED_ECHO_EN defined, each rx_byte SHALL also be pushed into the queue: a one-entry echo register is loaded on rx_valid and written when wr_valid is low and full is low (fabric has priority); wr_ready stays !full.
REQ-030 With echo, an rx_valid while the echo register is occupied SHALL overwrite it and set sticky output echo_drop (absent otherwise).
REQ-031 Without SPI_TX_SCHED_ECHO_EN, no echo register or echo_drop port SHALL exist and RAM writes come only from the fabric.

Verification
REQ-032 Push 8'hA5 when idle, then drop ce0 -> spi_tx_data=8'hA5 before frame_start, count 1->0 at frame_start, rptr=1.
REQ-033 Drop ce0 with an empty queue -> spi_tx_data=FILL_BYTE, underrun=1, count stays 0.
REQ-034 Push 256 bytes -> full=1, wr_ready=0, 257th push ignored; one frame -> count=255, wr_ready=1; wptr wraps to 0.
REQ-035 Frame with spi_rx_data=8'h3C then raise ce0 -> rx_valid one clk after SYNC_STAGES+1 clks, rx_byte=8'h3C.
REQ-036 Push and frame_start in the same cycle at count=5 -> count stays 5.
REQ-037 ECHO_EN: rx_byte 8'h11 while wr_valid held 3 cycles -> echo written the cycle after wr_valid drops, count +4 total.
